// File: rtl/stack_ctrl_mem.sv
// stack_ctrl_mem: storage and control for the processor hardware stack.
// Qualifies raw push/pop requests, hands the qualified strobes to the
// external stack_pointer, and uses its addr_w/addr_r to access a small
// asynchronous-read RAM. Holds a registered top-of-stack, the occupancy
// count, full/empty status and sticky overflow/underflow flags.
// The stack grows downwards: the first push lands at NDATAS-1.
module stack_ctrl_mem #(
  parameter int NDATAW = 8,   // address width, shared with stack_pointer
  parameter int NDATAS = 8,   // depth in words, 1..2^NDATAW
  parameter int NBITS  = 16   // data word width
) (
  input  logic              clk,
  input  logic              rst,      // asynchronous, active-low
  input  logic              push,
  input  logic              pop,
  input  logic              clr_err,
  input  logic [NBITS-1:0]  in,
  input  logic [NDATAW-1:0] addr_w,
  input  logic [NDATAW-1:0] addr_r,
  output logic              sp_push,
  output logic              sp_pop,
  output logic [NBITS-1:0]  out,
  output logic [NDATAW:0]   count,
  output logic              empty,
  output logic              full,
  output logic              ovf,
  output logic              unf
);

  // Index width of the RAM array; at least one bit so a depth-1 stack works.
  localparam int AW = (NDATAS > 1) ? $clog2(NDATAS) : 1;
  // Depth expressed in count width, so NDATAS == 2^NDATAW is representable.
  localparam logic [NDATAW:0] DEPTH = (NDATAW+1)'(NDATAS);
  localparam logic [NDATAW:0] ONE   = (NDATAW+1)'(1);

  logic [NBITS-1:0]  mem [0:NDATAS-1];

  logic [NDATAW:0]   count_reg, count_next;
  logic [NBITS-1:0]  out_reg, out_next;
  logic              ovf_reg, ovf_next;
  logic              unf_reg, unf_next;

  logic              push_rej;
  logic              pop_rej;
  logic              wr_in_range;
  logic              wr_en;
  logic [NDATAW-1:0] below_addr;
  logic              below_in_range;
  logic [NBITS-1:0]  below_word;

  // Status decode straight from the occupancy register.
  assign empty = (count_reg == '0);
  assign full  = (count_reg == DEPTH);

  // Push wins over pop; a pop paired with a push is silently dropped.
  assign sp_push  = push & ~full;
  assign sp_pop   = pop & ~push & ~empty;
  assign push_rej = push & full;
  assign pop_rej  = pop & ~push & empty;

  // The pointer only ever presents in-range addresses; the range guards keep
  // a stray address from aliasing onto a live entry of a non-power-of-2 RAM.
  assign wr_in_range = ({1'b0, addr_w} < DEPTH);
  // Writes are suppressed while reset is held, so a push under reset is ignored.
  assign wr_en       = sp_push & rst & wr_in_range;

  // Entry just below the current top: the value that becomes TOS after a pop.
  // addr_r is the current top and the stack grows down, so +1 never wraps when
  // at least two entries are present; the modulo add covers the other cases.
  assign below_addr     = addr_r + NDATAW'(1);
  assign below_in_range = ({1'b0, below_addr} < DEPTH);
  assign below_word     = below_in_range ? mem[below_addr[AW-1:0]] : '0;

  // RAM write port; deliberately not reset, contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr_w[AW-1:0]] <= in;
    end
  end

  // Next-state for occupancy, TOS and sticky error flags.
  always_comb begin
    count_next = count_reg;
    out_next   = out_reg;
    ovf_next   = ovf_reg;
    unf_next   = unf_reg;

    if (sp_push) begin
      count_next = count_reg + ONE;
      out_next   = in;
    end else if (sp_pop) begin
      count_next = count_reg - ONE;
      // Popping the last entry leaves nothing to show on TOS.
      out_next   = (count_reg == ONE) ? '0 : below_word;
    end

    // Clear first so that a same-cycle error event takes precedence.
    if (clr_err) begin
      ovf_next = 1'b0;
      unf_next = 1'b0;
    end
    if (push_rej) begin
      ovf_next = 1'b1;
    end
    if (pop_rej) begin
      unf_next = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
      out_reg   <= '0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      out_reg   <= out_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
    end
  end

  assign count = count_reg;
  assign out   = out_reg;
  assign ovf   = ovf_reg;
  assign unf   = unf_reg;

endmodule

// File: tb/tb_stack_ctrl_mem.sv
// tb_stack_ctrl_mem: directed and randomized checks of stack_ctrl_mem.
// The bench also plays the role of stack_pointer, deriving addr_w/addr_r
// from its own reference stack (a queue, top at the back).
module tb_stack_ctrl_mem;

  localparam int NDATAW = 8;
  localparam int NDATAS = 8;
  localparam int NBITS  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              push = 1'b0;
  logic              pop = 1'b0;
  logic              clr_err = 1'b0;
  logic [NBITS-1:0]  in = '0;
  logic [NDATAW-1:0] addr_w = '0;
  logic [NDATAW-1:0] addr_r = '0;
  logic              sp_push;
  logic              sp_pop;
  logic [NBITS-1:0]  out;
  logic [NDATAW:0]   count;
  logic              empty;
  logic              full;
  logic              ovf;
  logic              unf;

  int checks = 0;
  int errors = 0;

  // Reference model: stack contents and sticky flags.
  logic [NBITS-1:0] q[$];
  bit               m_ovf = 1'b0;
  bit               m_unf = 1'b0;

  stack_ctrl_mem #(
    .NDATAW(NDATAW),
    .NDATAS(NDATAS),
    .NBITS (NBITS)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .clr_err(clr_err),
    .in     (in),
    .addr_w (addr_w),
    .addr_r (addr_r),
    .sp_push(sp_push),
    .sp_pop (sp_pop),
    .out    (out),
    .count  (count),
    .empty  (empty),
    .full   (full),
    .ovf    (ovf),
    .unf    (unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pointer emulation: next free slot and current top, growing down from NDATAS-1.
  task automatic drive_addr();
    addr_w = NDATAW'(NDATAS - 1 - q.size());
    addr_r = NDATAW'(NDATAS - q.size());
  endtask

  task automatic check_state(input string tag);
    logic [NBITS-1:0] exp_out;
    exp_out = (q.size() > 0) ? q[$] : '0;
    chk({tag, " count"}, 32'(count), 32'(q.size()));
    chk({tag, " out"},   32'(out),   32'(exp_out));
    chk({tag, " empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, " full"},  32'(full),  32'(q.size() == NDATAS));
    chk({tag, " ovf"},   32'(ovf),   32'(m_ovf));
    chk({tag, " unf"},   32'(unf),   32'(m_unf));
  endtask

  // One clock of stimulus; called just after a rising edge.
  task automatic cycle(input bit p, input bit o, input bit c,
                       input logic [NBITS-1:0] d, input string tag);
    bit was_full, was_empty, acc_push, acc_pop;
    push = p; pop = o; clr_err = c; in = d;
    drive_addr();
    was_full  = (q.size() == NDATAS);
    was_empty = (q.size() == 0);
    acc_push  = p && !was_full;
    acc_pop   = o && !p && !was_empty;
    #1;
    chk({tag, " sp_push"}, 32'(sp_push), 32'(acc_push));
    chk({tag, " sp_pop"},  32'(sp_pop),  32'(acc_pop));
    @(posedge clk);
    if (acc_push) q.push_back(d);
    else if (acc_pop) void'(q.pop_back());
    m_ovf = (p && was_full) ? 1'b1 : (c ? 1'b0 : m_ovf);
    m_unf = (o && !p && was_empty) ? 1'b1 : (c ? 1'b0 : m_unf);
    #1;
    check_state(tag);
    $display("%-10s push=%0b pop=%0b clr=%0b in=%04h -> count=%0d out=%04h e=%0b f=%0b ovf=%0b unf=%0b",
             tag, p, o, c, d, count, out, empty, full, ovf, unf);
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
  endtask

  // Asynchronous reset pulse between edges, optionally with a push held.
  task automatic async_reset(input bit hold_push, input string tag);
    #2;
    push = hold_push; in = 16'hDEAD;
    drive_addr();
    rst = 1'b0;
    #1;
    q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    check_state({tag, " async"});
    @(posedge clk);
    #1;
    check_state({tag, " held"});
    $display("%-10s reset pulse, push held=%0b -> count=%0d out=%04h", tag, hold_push, count, out);
    push = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    logic [NBITS-1:0] w;
    // Reset state
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    rst = 1'b1;

    // 1: three pushes
    cycle(1, 0, 0, 16'h0011, "t1_push");
    cycle(1, 0, 0, 16'h0022, "t1_push");
    cycle(1, 0, 0, 16'h0033, "t1_push");
    chk("t1 out const", 32'(out), 32'h0033);
    chk("t1 count const", 32'(count), 32'd3);

    // 2: pop back down to empty
    cycle(0, 1, 0, 16'h0000, "t2_pop");
    chk("t2 out const a", 32'(out), 32'h0022);
    cycle(0, 1, 0, 16'h0000, "t2_pop");
    chk("t2 out const b", 32'(out), 32'h0011);
    cycle(0, 1, 0, 16'h0000, "t2_pop");
    chk("t2 out const c", 32'(out), 32'h0000);
    chk("t2 empty const", 32'(empty), 32'd1);

    // 3: fill, then overflow
    for (int i = 0; i < NDATAS; i++) begin
      w = NBITS'($urandom);
      cycle(1, 0, 0, w, "t3_fill");
    end
    cycle(1, 0, 0, 16'hBEEF, "t3_ovf");
    chk("t3 full const", 32'(full), 32'd1);
    chk("t3 ovf const", 32'(ovf), 32'd1);
    chk("t3 count const", 32'(count), 32'd8);
    for (int i = 0; i < NDATAS; i++) begin
      cycle(0, 1, 0, 16'h0000, "t3_drain");
    end

    // 4: underflow, then clear; a same-cycle error beats the clear
    cycle(0, 1, 0, 16'h0000, "t4_unf");
    chk("t4 unf const", 32'(unf), 32'd1);
    cycle(0, 0, 1, 16'h0000, "t4_clr");
    chk("t4 unf cleared", 32'(unf), 32'd0);
    cycle(0, 1, 1, 16'h0000, "t4_unfclr");
    chk("t4 unf wins", 32'(unf), 32'd1);
    cycle(0, 0, 1, 16'h0000, "t4_clr");

    // 5: push and pop together act as a push
    cycle(1, 0, 0, 16'h1111, "t5_push");
    cycle(1, 0, 0, 16'h2222, "t5_push");
    cycle(1, 1, 0, 16'h0A0A, "t5_both");
    chk("t5 count const", 32'(count), 32'd3);
    chk("t5 out const", 32'(out), 32'h0A0A);
    chk("t5 unf const", 32'(unf), 32'd0);

    // 6: reset mid-operation, then resume from the top address
    cycle(1, 0, 0, 16'h3333, "t6_push");
    async_reset(1'b1, "t6_rst");
    cycle(1, 0, 0, 16'h1234, "t6_push");
    cycle(1, 0, 0, 16'h5678, "t6_push");
    cycle(0, 1, 0, 16'h0000, "t6_pop");
    chk("t6 out const", 32'(out), 32'h1234);
    cycle(0, 1, 0, 16'h0000, "t6_pop");

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      bit rp, ro, rc;
      rp = ($urandom_range(0, 99) < 45);
      ro = ($urandom_range(0, 99) < 45);
      rc = ($urandom_range(0, 99) < 8);
      w  = NBITS'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        async_reset(rp, "rnd_rst");
      end else begin
        cycle(rp, ro, rc, w, "rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
